// File: rtl/warm_rst_seq_if.sv
// Warm-reset request/acknowledge bundle between a requester and warm_rst_seq.
// Handshake: warm_req_i is a level sampled every edge; acceptance is a one-cycle warm_ack_o pulse, after which the requester may drop warm_req_i.
interface warm_rst_seq_if;
  logic       warm_req_i;
  logic       warm_ack_o;
  logic       busy_o;
  logic [7:0] warm_cnt_o;
  logic [2:0] state_dbg;

  modport master (
    output warm_req_i,
    input  warm_ack_o,
    input  busy_o,
    input  warm_cnt_o,
    input  state_dbg
  );

  modport slave (
    input  warm_req_i,
    output warm_ack_o,
    output busy_o,
    output warm_cnt_o,
    output state_dbg
  );
endinterface

// File: rtl/warm_rst_seq.sv
// SPARC core reset sequencer: cold power-up ordering plus warm-reset teardown/re-run.
// Optional WARM_RST_PEND_EN: requests seen outside RUN are remembered and replace the next RUN entry.
module warm_rst_seq #(
  parameter int T_HOLD = 8,
  parameter int T_ARST = 8,
  parameter int T_CKEN = 8,
  parameter int T_GRST = 8,
  parameter int T_PD   = 4
) (
  input  logic          sys_clock_i,
  input  logic          sys_reset_i,
  warm_rst_seq_if.slave warm_bus,
  output logic          cluster_cken_o,
  output logic          cmp_grst_o,
  output logic          cmp_arst_o,
  output logic          ctu_tst_pre_grst_o,
  output logic          adbginit_o,
  output logic          gdbginit_o,
  output logic          sys_reset_final_o
);

  // Last counter value of each phase; a length of 0 behaves like 1.
  localparam logic [7:0] HOLD_LAST = (T_HOLD <= 1) ? 8'd0 : 8'(T_HOLD - 1);
  localparam logic [7:0] ARST_LAST = (T_ARST <= 1) ? 8'd0 : 8'(T_ARST - 1);
  localparam logic [7:0] CKEN_LAST = (T_CKEN <= 1) ? 8'd0 : 8'(T_CKEN - 1);
  localparam logic [7:0] GRST_LAST = (T_GRST <= 1) ? 8'd0 : 8'(T_GRST - 1);
  localparam logic [7:0] PD_LAST   = (T_PD   <= 1) ? 8'd0 : 8'(T_PD - 1);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_ARST     = 3'd1,
    S_CKEN     = 3'd2,
    S_GRST     = 3'd3,
    S_RUN      = 3'd4,
    S_PD_FINAL = 3'd5,
    S_PD_GRST  = 3'd6,
    S_PD_CKEN  = 3'd7
  } state_t;

  // Bit order: {cken, grst, arst, pre_grst, adbginit, gdbginit, final}
  localparam logic [6:0] HOLD_VEC = 7'b0000001;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] phase_last;
  logic [7:0] warm_cnt_q, warm_cnt_d;
  logic       phase_done;
  logic       pend_hit;
  logic       accept;
  logic       ack_q;
  logic       busy_q;
  logic [6:0] rst_vec_q, rst_vec_d;

  function automatic logic [6:0] decode(input state_t s);
    logic [6:0] v;
    case (s)
      S_HOLD:     v = 7'b0000001;
      S_ARST:     v = 7'b0010101;
      S_CKEN:     v = 7'b1011101;
      S_GRST:     v = 7'b1111111;
      S_RUN:      v = 7'b1111110;
      S_PD_FINAL: v = 7'b1111111;
      S_PD_GRST:  v = 7'b1011101;
      S_PD_CKEN:  v = 7'b0010101;
      default:    v = 7'b0000001;
    endcase
    return v;
  endfunction

`ifdef WARM_RST_PEND_EN
  logic pend_q, pend_d;

  // A request sampled on the GRST exit edge itself also diverts RUN.
  assign pend_hit = pend_q | warm_bus.warm_req_i;

  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d = 1'b0;
    end else if (state_q != S_RUN && warm_bus.warm_req_i) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign pend_hit = 1'b0;
`endif

  always_comb begin
    phase_last = 8'd0;
    case (state_q)
      S_HOLD:                          phase_last = HOLD_LAST;
      S_ARST:                          phase_last = ARST_LAST;
      S_CKEN:                          phase_last = CKEN_LAST;
      S_GRST:                          phase_last = GRST_LAST;
      S_PD_FINAL, S_PD_GRST, S_PD_CKEN: phase_last = PD_LAST;
      default:                         phase_last = 8'd0;
    endcase
  end

  assign phase_done = (cnt_q == phase_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:     if (phase_done) state_d = S_ARST;
      S_ARST:     if (phase_done) state_d = S_CKEN;
      S_CKEN:     if (phase_done) state_d = S_GRST;
      S_GRST:     if (phase_done) state_d = pend_hit ? S_PD_FINAL : S_RUN;
      S_RUN:      if (warm_bus.warm_req_i) state_d = S_PD_FINAL;
      S_PD_FINAL: if (phase_done) state_d = S_PD_GRST;
      S_PD_GRST:  if (phase_done) state_d = S_PD_CKEN;
      S_PD_CKEN:  if (phase_done) state_d = S_HOLD;
      default:    state_d = S_HOLD;
    endcase
  end

  always_comb begin
    accept     = (state_d == S_PD_FINAL) && (state_q != S_PD_FINAL);
    cnt_d      = ((state_d != state_q) || (state_q == S_RUN)) ? 8'd0 : cnt_q + 8'd1;
    warm_cnt_d = warm_cnt_q;
    if (state_q == S_PD_CKEN && state_d == S_HOLD && warm_cnt_q != 8'hFF) begin
      warm_cnt_d = warm_cnt_q + 8'd1;
    end
    rst_vec_d  = decode(state_d);
  end

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      state_q    <= S_HOLD;
      cnt_q      <= 8'd0;
      warm_cnt_q <= 8'd0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b1;
      rst_vec_q  <= HOLD_VEC;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      warm_cnt_q <= warm_cnt_d;
      ack_q      <= accept;
      busy_q     <= (state_d != S_RUN);
      rst_vec_q  <= rst_vec_d;
    end
  end

  assign cluster_cken_o      = rst_vec_q[6];
  assign cmp_grst_o          = rst_vec_q[5];
  assign cmp_arst_o          = rst_vec_q[4];
  assign ctu_tst_pre_grst_o  = rst_vec_q[3];
  assign adbginit_o          = rst_vec_q[2];
  assign gdbginit_o          = rst_vec_q[1];
  assign sys_reset_final_o   = rst_vec_q[0];

  assign warm_bus.warm_ack_o = ack_q;
  assign warm_bus.busy_o     = busy_q;
  assign warm_bus.warm_cnt_o = warm_cnt_q;
  assign warm_bus.state_dbg  = state_q;

  ack_only_in_pd_final: assert property (@(posedge sys_clock_i) disable iff (sys_reset_i)
    ack_q |-> (state_q == S_PD_FINAL));

  ack_single_cycle: assert property (@(posedge sys_clock_i) disable iff (sys_reset_i)
    ack_q |=> !ack_q);

  busy_tracks_state: assert property (@(posedge sys_clock_i) disable iff (sys_reset_i)
    busy_q == (state_q != S_RUN));

  outputs_track_state: assert property (@(posedge sys_clock_i) disable iff (sys_reset_i)
    rst_vec_q == decode(state_q));

  warm_cnt_saturates: assert property (@(posedge sys_clock_i) disable iff (sys_reset_i)
    (warm_cnt_q == 8'hFF) |=> (warm_cnt_q == 8'hFF));

endmodule

// File: tb/tb_warm_rst_seq.sv
// Self-checking bench for warm_rst_seq: default-timing instance (a) and minimum-timing instance (b).
// Build with +define+WARM_RST_PEND_EN to check the pending-request variant.
module tb_warm_rst_seq;

  localparam int ST_HOLD     = 0;
  localparam int ST_ARST     = 1;
  localparam int ST_CKEN     = 2;
  localparam int ST_GRST     = 3;
  localparam int ST_RUN      = 4;
  localparam int ST_PD_FINAL = 5;
  localparam int ST_PD_GRST  = 6;
  localparam int ST_PD_CKEN  = 7;

`ifdef WARM_RST_PEND_EN
  localparam int P_FAST  = 7;
  localparam int B2B_GAP = 44;
`else
  localparam int P_FAST  = 8;
  localparam int B2B_GAP = 45;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  warm_rst_seq_if bus_a ();
  warm_rst_seq_if bus_b ();

  logic cken_a, grst_a, arst_a, pre_a, adbg_a, gdbg_a, fin_a;
  logic cken_b, grst_b, arst_b, pre_b, adbg_b, gdbg_b, fin_b;

  warm_rst_seq dut_a (
    .sys_clock_i        (clk),
    .sys_reset_i        (rst_a),
    .warm_bus           (bus_a),
    .cluster_cken_o     (cken_a),
    .cmp_grst_o         (grst_a),
    .cmp_arst_o         (arst_a),
    .ctu_tst_pre_grst_o (pre_a),
    .adbginit_o         (adbg_a),
    .gdbginit_o         (gdbg_a),
    .sys_reset_final_o  (fin_a)
  );

  warm_rst_seq #(.T_HOLD(1), .T_ARST(1), .T_CKEN(1), .T_GRST(1), .T_PD(0)) dut_b (
    .sys_clock_i        (clk),
    .sys_reset_i        (rst_b),
    .warm_bus           (bus_b),
    .cluster_cken_o     (cken_b),
    .cmp_grst_o         (grst_b),
    .cmp_arst_o         (arst_b),
    .ctu_tst_pre_grst_o (pre_b),
    .adbginit_o         (adbg_b),
    .gdbginit_o         (gdbg_b),
    .sys_reset_final_o  (fin_b)
  );

  logic [16:0] obs_a, obs_b;
  assign obs_a = {cken_a, grst_a, arst_a, pre_a, adbg_a, gdbg_a, fin_a,
                  bus_a.busy_o, bus_a.warm_ack_o, bus_a.warm_cnt_o};
  assign obs_b = {cken_b, grst_b, arst_b, pre_b, adbg_b, gdbg_b, fin_b,
                  bus_b.busy_o, bus_b.warm_ack_o, bus_b.warm_cnt_o};

  // ---------------- scoreboard ----------------
  // Entry: {dut_sel, cycle[19:0], expected {resets[6:0], busy, ack, cnt[7:0]}}
  logic [37:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] exp_vec(input int st, input logic ack, input logic [7:0] cnt);
    logic [6:0] o;
    case (st)
      ST_HOLD:     o = 7'b0000001;
      ST_ARST:     o = 7'b0010101;
      ST_CKEN:     o = 7'b1011101;
      ST_GRST:     o = 7'b1111111;
      ST_RUN:      o = 7'b1111110;
      ST_PD_FINAL: o = 7'b1111111;
      ST_PD_GRST:  o = 7'b1011101;
      default:     o = 7'b0010101;
    endcase
    return {o, (st != ST_RUN), ack, cnt};
  endfunction

  task automatic push(input logic sel, input int c, input int st, input logic ack,
                      input int cnt, input string tag);
    exp_q.push_back({sel, 20'(c), exp_vec(st, ack, 8'(cnt))});
    tag_q.push_back($sformatf("%s_%s@%0d", sel ? "b" : "a", tag, c));
  endtask

  logic [37:0] mon_e;
  string       mon_t;
  int          mon_c;

  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && int'(exp_q[0][36:17]) <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_c = int'(mon_e[36:17]);
      if (mon_c < cyc) check({mon_t, "_missed"}, 32'(cyc), 32'(mon_c));
      else             check(mon_t, mon_e[37] ? obs_b : obs_a, mon_e[16:0]);
    end
  end

  task automatic drain(input int budget);
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic do_reset(input logic sel, output int r);
    @(negedge clk);
    if (sel) begin rst_b = 1'b1; bus_b.warm_req_i = 1'b0; end
    else     begin rst_a = 1'b1; bus_a.warm_req_i = 1'b0; end
    r = cyc + 1;
    push(sel, r, ST_HOLD, 1'b0, 0, "rst");
    @(negedge clk);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
  endtask

  // Request sampled on edge e only.
  task automatic pulse_a(input int e);
    at_cyc(e - 1);
    bus_a.warm_req_i = 1'b1;
    at_cyc(e);
    bus_a.warm_req_i = 1'b0;
  endtask

  int r, e, a2, base;

  initial begin
    bus_a.warm_req_i = 1'b0;
    bus_b.warm_req_i = 1'b0;

    // Cold boot with a stray request during power-up
    do_reset(1'b0, r);
    push(0, r + 7,  ST_HOLD, 0, 0, "hold_end");
    push(0, r + 8,  ST_ARST, 0, 0, "arst_rise");
    push(0, r + 10, ST_ARST, 0, 0, "req_no_ack");
    push(0, r + 15, ST_ARST, 0, 0, "arst_end");
    push(0, r + 16, ST_CKEN, 0, 0, "cken_rise");
    push(0, r + 24, ST_GRST, 0, 0, "grst_rise");
    push(0, r + 31, ST_GRST, 0, 0, "grst_end");
`ifdef WARM_RST_PEND_EN
    push(0, r + 32, ST_PD_FINAL, 1, 0, "pend_ack");
    push(0, r + 33, ST_PD_FINAL, 0, 0, "pend_ack_drop");
    push(0, r + 44, ST_HOLD, 0, 1, "pend_done");
    push(0, r + 76, ST_RUN,  0, 1, "pend_run");
    base = 1;
`else
    push(0, r + 32, ST_RUN, 0, 0, "run");
    push(0, r + 40, ST_RUN, 0, 0, "run_steady");
    base = 0;
`endif
    pulse_a(r + 10);
    drain(200);

    // Single warm reset from RUN
    e = cyc + 3;
    push(0, e,      ST_PD_FINAL, 1, base,     "warm_ack");
    push(0, e + 1,  ST_PD_FINAL, 0, base,     "warm_ack_drop");
    push(0, e + 3,  ST_PD_FINAL, 0, base,     "pd_final_end");
    push(0, e + 4,  ST_PD_GRST,  0, base,     "grst_fall");
    push(0, e + 8,  ST_PD_CKEN,  0, base,     "cken_fall");
    push(0, e + 11, ST_PD_CKEN,  0, base,     "pd_cken_end");
    push(0, e + 12, ST_HOLD,     0, base + 1, "arst_fall");
    push(0, e + 43, ST_GRST,     0, base + 1, "rerun_grst");
    push(0, e + 44, ST_RUN,      0, base + 1, "rerun_run");
    pulse_a(e);
    drain(200);
    base++;

    // Reset mid-teardown with a same-edge request
    e = cyc + 3;
    push(0, e,      ST_PD_FINAL, 1, base, "td_ack");
    push(0, e + 4,  ST_PD_GRST,  0, base, "td_grst");
    push(0, e + 6,  ST_HOLD,     0, 0,    "td_reset");
    push(0, e + 13, ST_HOLD,     0, 0,    "td_hold_end");
    push(0, e + 14, ST_ARST,     0, 0,    "td_arst");
    push(0, e + 22, ST_CKEN,     0, 0,    "td_cken");
    push(0, e + 30, ST_GRST,     0, 0,    "td_grst2");
    push(0, e + 38, ST_RUN,      0, 0,    "td_run");
    pulse_a(e);
    at_cyc(e + 5);
    rst_a = 1'b1;
    bus_a.warm_req_i = 1'b1;
    at_cyc(e + 6);
    rst_a = 1'b0;
    bus_a.warm_req_i = 1'b0;
    drain(200);

    // Request held high: back-to-back warm resets
    e  = cyc + 3;
    a2 = e + B2B_GAP;
    push(0, e,      ST_PD_FINAL, 1, 0, "b2b_ack1");
    push(0, e + 12, ST_HOLD,     0, 1, "b2b_done1");
    push(0, e + 43, ST_GRST,     0, 1, "b2b_grst");
`ifndef WARM_RST_PEND_EN
    push(0, e + 44, ST_RUN,      0, 1, "b2b_run1");
`endif
    push(0, a2,      ST_PD_FINAL, 1, 1, "b2b_ack2");
    push(0, a2 + 1,  ST_PD_FINAL, 0, 1, "b2b_ack2_drop");
    push(0, a2 + 12, ST_HOLD,     0, 2, "b2b_done2");
    push(0, a2 + 44, ST_RUN,      0, 2, "b2b_run2");
    at_cyc(e - 1);
    bus_a.warm_req_i = 1'b1;
`ifdef WARM_RST_PEND_EN
    at_cyc(a2 - 1);
`else
    at_cyc(a2);
`endif
    bus_a.warm_req_i = 1'b0;
    drain(300);

    // Minimum timing and warm count saturation on instance b
    do_reset(1'b1, r);
    push(1, r + 1, ST_ARST, 0, 0, "min_arst");
    push(1, r + 2, ST_CKEN, 0, 0, "min_cken");
    push(1, r + 3, ST_GRST, 0, 0, "min_grst");
    push(1, r + 4, ST_RUN,  0, 0, "min_run");
    e = r + 6;
    push(1, e,     ST_PD_FINAL, 1, 0, "min_ack");
    push(1, e + 1, ST_PD_GRST,  0, 0, "min_pd_grst");
    push(1, e + 2, ST_PD_CKEN,  0, 0, "min_pd_cken");
    push(1, e + 3, ST_HOLD,     0, 1, "min_hold");
    push(1, e + 4, ST_ARST,     0, 1, "min_arst2");
    push(1, e + 5, ST_CKEN,     0, 1, "min_cken2");
    push(1, e + 6, ST_GRST,     0, 1, "min_grst2");
`ifdef WARM_RST_PEND_EN
    push(1, e + 7, ST_PD_FINAL, 1, 1, "min_reack");
`else
    push(1, e + 7, ST_RUN,      0, 1, "min_run2");
    push(1, e + 8, ST_PD_FINAL, 1, 1, "min_reack");
`endif
    push(1, e + 253 * P_FAST + 3, ST_HOLD,    0, 254, "sat_254");
    push(1, e + 254 * P_FAST + 2, ST_PD_CKEN, 0, 254, "sat_pre255");
    push(1, e + 254 * P_FAST + 3, ST_HOLD,    0, 255, "sat_255");
    push(1, e + 255 * P_FAST + 3, ST_HOLD,    0, 255, "sat_256th");
    push(1, e + 259 * P_FAST + 3, ST_HOLD,    0, 255, "sat_hold");
    at_cyc(e - 1);
    bus_b.warm_req_i = 1'b1;
    at_cyc(e + 260 * P_FAST);
    bus_b.warm_req_i = 1'b0;
    drain(3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
